sram_handshake_adapter: RTL
===========================

// Module: sram_handshake_adapter
// PURPOSE
// - Valid/ready front end for the single-port, 1-cycle-latency tc_sram macro array.
// - Turns a backpressured request stream into SRAM strobes and returns read data as a
//   backpressured response stream, in order.
// - Sits between the cache/LSU request arbiter and tc_sram.
// - A tc_sram read result exists for exactly one cycle; this block captures it into a
//   response FIFO so no data is lost under backpressure.
// PARAMETERS
// - NumWords      1024  SRAM depth in words
// - DataWidth     128   data width (bits)
// - ByteWidth     8     bits per byte-enable lane
// - RspDepth      2     response FIFO depth = max outstanding reads; >=2 for full rate
// - AddrWidth     derived $clog2(NumWords) (1 if NumWords==1)
// - BeWidth       derived ceil(DataWidth/ByteWidth)
// PORTS
// - clk_i         in   1          clock; single clock domain
// - rst_ni        in   1          asynchronous reset, active-low
// - req_valid_i   in   1          request valid
// - req_ready_o   out  1          request ready
// - req_we_i      in   1          1 = write, 0 = read
// - req_addr_i    in   AddrWidth  word address
// - req_wdata_i   in   DataWidth  write data
// - req_be_i      in   BeWidth    write byte enables
// - rsp_valid_o   out  1          response valid
// - rsp_ready_i   in   1          response ready
// - rsp_rdata_o   out  DataWidth  response data
// - sram_req_o    out  1          to tc_sram req_i
// - sram_we_o     out  1          to tc_sram we_i
// - sram_addr_o   out  AddrWidth  to tc_sram addr_i
// - sram_wdata_o  out  DataWidth  to tc_sram wdata_i
// - sram_be_o     out  BeWidth    to tc_sram be_i
// - sram_rdata_i  in   DataWidth  from tc_sram rdata_o; valid only the cycle after a read
// BEHAVIOUR
// - Handshake
//   - A request is accepted on req_valid_i & req_ready_o.
//   - sram_req_o = accepted, in the same cycle; combinational path.
//   - sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o pass req_* through.
//   - sram_req_o is never high without acceptance.
// - Credits
//   - inflight_q = 1 iff a response-producing request was accepted last cycle.
//   - count_q = FIFO occupancy, 0..RspDepth.
//   - credit = (count_q + inflight_q) < RspDepth.
//   - credit is a pure function of state: no combinational path rsp_ready_i -> req_ready_o.
//   - Read: req_ready_o = credit.
//   - Write: see CONFIGURATION.
// - Response path (cycle after a read issue)
//   - FIFO empty: sram_rdata_i falls through to rsp_rdata_o with rsp_valid_o=1; latency 1.
//   - Fall-through accepted by rsp_ready_i: not stored.
//   - Fall-through not accepted: pushed to FIFO tail.
//   - FIFO non-empty: rsp_rdata_o = FIFO head; arriving data always pushed to tail.
//   - Order always preserved.
// - FIFO limits
//   - Pop and push in the same cycle: count_q unchanged.
//   - The credit rule guarantees no push when full.
//   - Full: count_q == RspDepth -> req_ready_o=0 for reads.
//   - Empty and inflight_q==0: rsp_valid_o=0.
//   - Read/write pointers wrap modulo RspDepth; RspDepth need not be a power of 2.
// - Reset (rst_ni low, any time, including mid-transfer)
//   - count_q=0, pointers=0, inflight_q=0.
//   - A read issued in the reset cycle yields no response.
//   - Outputs in reset: req_ready_o=1, rsp_valid_o=0, sram_req_o=0, rsp_rdata_o='0 while empty.
// - Assertions (ifndef SYNTHESIS)
//   - RspDepth>=1.
//   - No FIFO overflow/underflow.
//   - rsp_* stable while rsp_valid_o & !rsp_ready_i.
// CONFIGURATION
// - Macro SRAM_ADAPTER_WRITE_RSP_EN
//   - Defined: every write yields one response with rsp_rdata_o='0 (write ack).
//   - Defined: writes consume a credit exactly like reads; req_ready_o = credit for all requests.
//   - Undefined: writes yield no response and consume no credit.
//   - Undefined: req_ready_o = req_we_i | credit.
// TESTING
// - Reset: rst_ni=0 -> req_ready_o=1, rsp_valid_o=0, sram_req_o=0.
// - Single read
//   - Stimulus: write 0x11..11 to addr 5, then read addr 5, rsp_ready_i=1.
//   - Required: rsp_valid_o=1 exactly 1 cycle after read accept, data 0x11..11.
// - Streaming
//   - Stimulus: 16 back-to-back reads of addr 0..15 (preloaded data=addr), RspDepth=2,
//     rsp_ready_i=1.
//   - Required: req_ready_o stays 1; responses 0..15 in 16 consecutive cycles.
// - Backpressure
//   - Stimulus: reads addr 1,2,3 with rsp_ready_i=0.
//   - Required: only 2 accepted, req_ready_o=0, count_q=2.
//   - Then rsp_ready_i=1: responses 1,2 drain in order, addr 3 accepted next,
//     nothing lost or duplicated.
// - Writes, macro undefined
//   - Stimulus: FIFO full, write addr 7 data 0xAB.
//   - Required: write accepted, no response; later read addr 7 returns 0xAB.
// - Writes, macro defined: same stimulus -> write stalls until a credit frees, then
//   produces one response with rdata=0.
// - Mid-operation reset: reset asserted with 2 queued and 1 inflight -> after release
//   rsp_valid_o=0 and no stale response ever appears.

Source files
------------

// File: rtl/sram_handshake_adapter_if.sv
// rtl/sram_handshake_adapter_if.sv - request/response/SRAM signal bundle for sram_handshake_adapter
interface sram_handshake_adapter_if #(
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned DataWidth = 128,
    parameter int unsigned ByteWidth = 8
);
    localparam int unsigned AddrWidth = (NumWords == 1) ? 1 : $clog2(NumWords);
    localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth;

    logic                 req_valid_i;
    logic                 req_ready_o;
    logic                 req_we_i;
    logic [AddrWidth-1:0] req_addr_i;
    logic [DataWidth-1:0] req_wdata_i;
    logic [BeWidth-1:0]   req_be_i;

    logic                 rsp_valid_o;
    logic                 rsp_ready_i;
    logic [DataWidth-1:0] rsp_rdata_o;

    logic                 sram_req_o;
    logic                 sram_we_o;
    logic [AddrWidth-1:0] sram_addr_o;
    logic [DataWidth-1:0] sram_wdata_o;
    logic [BeWidth-1:0]   sram_be_o;
    logic [DataWidth-1:0] sram_rdata_i;

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i,
        output req_ready_o,
        output rsp_valid_o, rsp_rdata_o,
        input  rsp_ready_i,
        output sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o,
        input  sram_rdata_i
    );

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i,
        input  req_ready_o,
        input  rsp_valid_o, rsp_rdata_o,
        output rsp_ready_i,
        input  sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o,
        output sram_rdata_i
    );
endinterface

// File: rtl/sram_handshake_adapter.sv
// rtl/sram_handshake_adapter.sv - valid/ready front end for a 1-cycle-latency single-port SRAM
// Optional write acknowledgements: define SRAM_ADAPTER_WRITE_RSP_EN.
module sram_handshake_adapter #(
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned DataWidth = 128,
    parameter int unsigned ByteWidth = 8,
    parameter int unsigned RspDepth  = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    sram_handshake_adapter_if.slave bus
);
    localparam int unsigned AddrWidth = (NumWords == 1) ? 1 : $clog2(NumWords);
    localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth;
    localparam int unsigned CntWidth  = $clog2(RspDepth + 1);
    localparam int unsigned PtrWidth  = (RspDepth > 1) ? $clog2(RspDepth) : 1;

    logic [CntWidth-1:0]  count_q, count_d;
    logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]  rd_ptr_q, rd_ptr_d;
    logic                 inflight_q, inflight_d;
    logic                 inflight_wr_q, inflight_wr_d;
    logic [DataWidth-1:0] mem_q [RspDepth];
    logic [DataWidth-1:0] mem_d [RspDepth];

    logic                 credit;
    logic                 req_ready;
    logic                 accept;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 rsp_valid;
    logic [DataWidth-1:0] arrive_data;
    logic [DataWidth-1:0] rsp_rdata;

    always_comb begin
        credit = (32'(count_q) + 32'(inflight_q)) < RspDepth;
`ifdef SRAM_ADAPTER_WRITE_RSP_EN
        req_ready = credit;
`else
        req_ready = bus.req_we_i | credit;
`endif
        // Gating with rst_ni keeps a request presented during reset from reaching the SRAM.
        accept = rst_ni & bus.req_valid_i & req_ready;
`ifdef SRAM_ADAPTER_WRITE_RSP_EN
        inflight_d    = accept;
        inflight_wr_d = accept & bus.req_we_i;
`else
        inflight_d    = accept & ~bus.req_we_i;
        inflight_wr_d = 1'b0;
`endif
        arrive_data = inflight_wr_q ? '0 : bus.sram_rdata_i;
        empty       = (count_q == '0);
        rsp_valid   = ~empty | inflight_q;
        rsp_rdata   = '0;
        if (!empty) begin
            rsp_rdata = mem_q[rd_ptr_q];
        end else if (inflight_q) begin
            rsp_rdata = arrive_data;
        end

        pop  = ~empty & bus.rsp_ready_i;
        push = inflight_q & ~(empty & bus.rsp_ready_i);

        count_d  = count_q + CntWidth'(push) - CntWidth'(pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = arrive_data;
            wr_ptr_d = (wr_ptr_q == PtrWidth'(RspDepth - 1)) ? '0 : wr_ptr_q + PtrWidth'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrWidth'(RspDepth - 1)) ? '0 : rd_ptr_q + PtrWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            inflight_q    <= 1'b0;
            inflight_wr_q <= 1'b0;
        end else begin
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            inflight_q    <= inflight_d;
            inflight_wr_q <= inflight_wr_d;
        end
    end

    // Storage needs no reset: only entries below count_q are ever observed.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign bus.req_ready_o  = req_ready;
    assign bus.rsp_valid_o  = rsp_valid;
    assign bus.rsp_rdata_o  = rsp_rdata;
    assign bus.sram_req_o   = accept;
    assign bus.sram_we_o    = bus.req_we_i;
    assign bus.sram_addr_o  = AddrWidth'(bus.req_addr_i);
    assign bus.sram_wdata_o = bus.req_wdata_i;
    assign bus.sram_be_o    = BeWidth'(bus.req_be_i);

`ifndef SYNTHESIS
    a_depth_ok: assert property (@(posedge clk_i) RspDepth >= 1);
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && !pop && count_q == CntWidth'(RspDepth)));
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(pop && empty));
    a_rsp_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (rsp_valid && !bus.rsp_ready_i) |=> (rsp_valid && $stable(rsp_rdata)));
`endif
endmodule
